// File: rtl/led_pwm_driver_if.sv
// Config bus between the CPU register block and the LED PWM driver.
interface led_pwm_driver_if;
    logic        cfg_we;
    logic [31:0] cfg_data;
    logic [31:0] o_cfg;
    logic        o_pending;

    // CPU side: writes config, reads back active config and pending flag
    modport master (
        output cfg_we,
        output cfg_data,
        input  o_cfg,
        input  o_pending
    );

    // Driver side
    modport slave (
        input  cfg_we,
        input  cfg_data,
        output o_cfg,
        output o_pending
    );
endinterface

// File: rtl/led_pwm_driver.sv
// LED pin driver: PWM brightness and per-LED blink, with config shadowed to PWM period boundaries.
module led_pwm_driver #(
    parameter int unsigned      CNT_W    = 8,
    parameter int unsigned      BLK_W    = 8,
    parameter logic [CNT_W-1:0] RST_DUTY = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        i_leds,
    led_pwm_driver_if.slave   cfg,
    output logic [3:0]        o_pins,
    output logic              o_period_start
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0]      USED_BITS = 32'h0F0F_0000 | ((32'd1 << CNT_W) - 32'd1);

    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] duty_shd;
    logic [3:0]       mask_act;
    logic [3:0]       mask_shd;
    logic [3:0]       rate_act;
    logic [3:0]       rate_shd;
    logic [BLK_W-1:0] blk_cnt;
    logic             blink_phase;
    logic             pending;

    logic             boundary;
    logic             pwm_on;
    logic [7:0]       blk_term_full;
    logic [BLK_W-1:0] blk_term;
    logic [3:0]       pins_nxt;
    logic [31:0]      cfg_rd;
    logic [CNT_W-1:0] wr_duty;
    logic [3:0]       wr_mask;
    logic [3:0]       wr_rate;
    logic [31:0]      unused_cfg_bits;

    // Decode of write data fields and the bits this block ignores
    always_comb begin
        wr_duty         = cfg.cfg_data[CNT_W-1:0];
        wr_mask         = cfg.cfg_data[19:16];
        wr_rate         = cfg.cfg_data[27:24];
        unused_cfg_bits = cfg.cfg_data & ~USED_BITS;
    end

    // Period boundary, PWM compare, blink terminal count and next pin value
    always_comb begin
        boundary      = (pwm_cnt == CNT_MAX);
        if (duty_act == '0) begin
            pwm_on = 1'b0;
        end else if (duty_act == CNT_MAX) begin
            pwm_on = 1'b1;
        end else begin
            pwm_on = (pwm_cnt < duty_act);
        end
        blk_term_full = {rate_act, 4'hF};
        blk_term      = BLK_W'(blk_term_full);
        pins_nxt      = i_leds & {4{pwm_on}} & (~mask_act | {4{blink_phase}});
    end

    // Active config readback, unused bits zero
    always_comb begin
        cfg_rd                = '0;
        cfg_rd[CNT_W-1:0]     = duty_act;
        cfg_rd[19:16]         = mask_act;
        cfg_rd[27:24]         = rate_act;
        cfg.o_cfg             = cfg_rd;
        cfg.o_pending         = pending;
    end

    // Free-running PWM counter and blink divider in units of PWM periods
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt     <= '0;
            blk_cnt     <= '0;
            blink_phase <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (boundary) begin
                // >= so a shrinking rate still terminates promptly
                if (blk_cnt >= blk_term) begin
                    blk_cnt     <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
        end
    end

    // Shadow/active config: writes land in shadow, promoted at the period boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_act <= RST_DUTY;
            mask_act <= '0;
            rate_act <= '0;
            duty_shd <= RST_DUTY;
            mask_shd <= '0;
            rate_shd <= '0;
            pending  <= 1'b0;
        end else if (boundary) begin
            // A write in the boundary cycle bypasses the shadow
            if (cfg.cfg_we) begin
                duty_act <= wr_duty;
                mask_act <= wr_mask;
                rate_act <= wr_rate;
                duty_shd <= wr_duty;
                mask_shd <= wr_mask;
                rate_shd <= wr_rate;
            end else begin
                duty_act <= duty_shd;
                mask_act <= mask_shd;
                rate_act <= rate_shd;
            end
            pending <= 1'b0;
        end else if (cfg.cfg_we) begin
            duty_shd <= wr_duty;
            mask_shd <= wr_mask;
            rate_shd <= wr_rate;
            pending  <= 1'b1;
        end
    end

    // Registered pin drive and period-start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            o_pins         <= '0;
            o_period_start <= 1'b0;
        end else begin
            o_pins         <= pins_nxt;
            o_period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with CNT_W=4 (16-cycle PWM period).
module tb_led_pwm_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i_leds;
    logic [3:0] o_pins;
    logic       o_period_start;

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;   // cycles since last reset release
    int cnt   = 0;   // expected pwm_cnt in the current cycle

    led_pwm_driver_if cfg_bus ();

    led_pwm_driver #(
        .CNT_W    (4),
        .BLK_W    (8),
        .RST_DUTY (4'hF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_leds         (i_leds),
        .cfg            (cfg_bus.slave),
        .o_pins         (o_pins),
        .o_period_start (o_period_start)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0d cnt=%0d)", tag, got, exp, t, cnt);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        t   = t + 1;
        cnt = (cnt + 1) % 16;
    endtask

    task automatic run_to(input int c);
        while (cnt != c) tick();
    endtask

    task automatic write_cfg(input logic [31:0] d);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_data = d;
        tick();
        cfg_bus.cfg_we   = 1'b0;
    endtask

    // Expected blink phase per PWM period for the blink scenario
    function automatic logic blink_exp(input int p);
        if (p < 16)      return 1'b1;
        else if (p < 80) return 1'b0;
        else if (p < 96) return 1'b1;
        else             return 1'b0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ph;
        rst              = 1'b1;
        i_leds           = 4'hF;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_data = '0;

        // Reset state
        tick();
        tick();
        chk("rst_pins",    32'(o_pins), 32'h0);
        chk("rst_pending", 32'(cfg_bus.o_pending), 32'h0);
        chk("rst_cfg",     cfg_bus.o_cfg, 32'h0000_000F);
        chk("rst_pstart",  32'(o_period_start), 32'h0);
        rst = 1'b0;
        t   = 0;
        cnt = 0;
        chk("rel_pins", 32'(o_pins), 32'h0);
        repeat (17) begin
            tick();
            chk("full_duty_pins", 32'(o_pins), 32'hF);
            chk("pstart", 32'(o_period_start), (cnt == 0) ? 32'h1 : 32'h0);
        end

        // Duty 25%, written mid-period
        i_leds = 4'h5;
        run_to(5);
        write_cfg(32'h0000_0004);
        chk("d25_pending", 32'(cfg_bus.o_pending), 32'h1);
        chk("d25_old_cfg", cfg_bus.o_cfg, 32'h0000_000F);
        chk("d25_old_pins", 32'(o_pins), 32'h5);
        run_to(15);
        chk("d25_pending_late", 32'(cfg_bus.o_pending), 32'h1);
        tick();
        chk("d25_applied_pend", 32'(cfg_bus.o_pending), 32'h0);
        chk("d25_applied_cfg", cfg_bus.o_cfg, 32'h0000_0004);
        chk("d25_old_tail", 32'(o_pins), 32'h5);
        repeat (32) begin
            tick();
            chk("d25_pins", 32'(o_pins), (((cnt + 15) % 16) < 4) ? 32'h5 : 32'h0);
        end

        // Duty 0: dark for a whole period
        run_to(3);
        write_cfg(32'h0000_0000);
        run_to(0);
        repeat (16) begin
            tick();
            chk("d0_pins", 32'(o_pins), 32'h0);
        end

        // Duty MAX: pins follow i_leds
        i_leds = 4'hA;
        run_to(3);
        write_cfg(32'h0000_000F);
        run_to(0);
        repeat (16) begin
            tick();
            chk("dmax_pins", 32'(o_pins), 32'hA);
        end

        // i_leds off overrides any duty
        i_leds = 4'h0;
        run_to(3);
        write_cfg(32'h0000_0007);
        run_to(0);
        repeat (16) begin
            tick();
            chk("leds_off_pins", 32'(o_pins), 32'h0);
        end

        // Two writes in one period: last wins
        i_leds = 4'hF;
        run_to(2);
        write_cfg(32'h0000_0003);
        run_to(6);
        write_cfg(32'h0000_0009);
        chk("coll_pending", 32'(cfg_bus.o_pending), 32'h1);
        chk("coll_old_cfg", cfg_bus.o_cfg, 32'h0000_0007);
        run_to(0);
        chk("coll_cfg", cfg_bus.o_cfg, 32'h0000_0009);
        chk("coll_pend_clr", 32'(cfg_bus.o_pending), 32'h0);
        repeat (16) begin
            tick();
            chk("coll_pins", 32'(o_pins), (((cnt + 15) % 16) < 9) ? 32'hF : 32'h0);
        end

        // Write in the boundary cycle applies immediately
        run_to(15);
        write_cfg(32'h0000_0006);
        chk("bnd_pending", 32'(cfg_bus.o_pending), 32'h0);
        chk("bnd_cfg", cfg_bus.o_cfg, 32'h0000_0006);
        repeat (16) begin
            tick();
            chk("bnd_pend_low", 32'(cfg_bus.o_pending), 32'h0);
            chk("bnd_pins", 32'(o_pins), (((cnt + 15) % 16) < 6) ? 32'hF : 32'h0);
        end

        // Blink: fresh reset so the divider starts from zero
        i_leds = 4'h3;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        t   = 0;
        cnt = 0;
        while (t < 98 * 16) begin
            cfg_bus.cfg_we = 1'b0;
            if (t == 3) begin
                cfg_bus.cfg_we   = 1'b1;
                cfg_bus.cfg_data = 32'h0001_000F;
            end
            if (t == 26 * 16 + 4) begin
                cfg_bus.cfg_we   = 1'b1;
                cfg_bus.cfg_data = 32'h0301_000F;
            end
            if (t == 81 * 16 + 4) begin
                cfg_bus.cfg_we   = 1'b1;
                cfg_bus.cfg_data = 32'h0001_000F;
            end
            tick();
            cfg_bus.cfg_we = 1'b0;
            ph = blink_exp((t - 1) / 16);
            chk("blink_pins", 32'(o_pins), 32'({2'b00, 1'b1, ph}));
            if (t == 26 * 16 + 5) chk("blink_r3_pending", 32'(cfg_bus.o_pending), 32'h1);
            if (t == 27 * 16)     chk("blink_r3_cfg", cfg_bus.o_cfg, 32'h0301_000F);
        end

        // Reset mid-operation with a pending write and blink running
        run_to(4);
        write_cfg(32'h0000_0003);
        chk("mid_pending", 32'(cfg_bus.o_pending), 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_pins",    32'(o_pins), 32'h0);
        chk("mid_rst_pending", 32'(cfg_bus.o_pending), 32'h0);
        chk("mid_rst_cfg",     cfg_bus.o_cfg, 32'h0000_000F);
        chk("mid_rst_pstart",  32'(o_period_start), 32'h0);
        rst = 1'b0;
        t   = 0;
        cnt = 0;
        repeat (17) begin
            tick();
            chk("post_rst_pins", 32'(o_pins), 32'h3);
            chk("post_rst_cfg", cfg_bus.o_cfg, 32'h0000_000F);
            chk("post_rst_pend", 32'(cfg_bus.o_pending), 32'h0);
        end
        run_to(3);
        write_cfg(32'h0001_000F);
        chk("post_rst_wr_pend", 32'(cfg_bus.o_pending), 32'h1);
        while (t < 7 * 16) begin
            tick();
            chk("post_rst_blink", 32'(o_pins), 32'h3);
        end
        chk("post_rst_blink_cfg", cfg_bus.o_cfg, 32'h0001_000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
